// File: rtl/fp_pair_stream_feeder.sv
// fp_pair_stream_feeder: buffers {B,A} float32 pairs from an AXI-Stream slave and presents one
// pair per transfer to the 16-lane FP dual-input distributor, tracking lane position and
// completed vectors. Operand bits pass through untouched.
//
// Build option: define FP_FEEDER_PAD_EN to pad every vector with zero pairs up to a whole
// lane group, so that out_finish always lands on lane LANES-1. Without it, out_finish
// follows tlast on whatever lane the last pair lands.
module fp_pair_stream_feeder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LANES      = 16,
    parameter int unsigned LANE_W     = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [2*DATA_W-1:0]           s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tuser,
    input  logic                          sendable,
    output logic [DATA_W-1:0]             out_A,
    output logic [DATA_W-1:0]             out_B,
    output logic                          out_valid,
    output logic                          out_finish,
    output logic                          out_acc_sign,
    output logic [LANE_W-1:0]             lane_idx,
    output logic [15:0]                   vec_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef struct packed {
        logic              user;
        logic              last;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } entry_t;

    // ------------------------------------------------------------------
    // Pair FIFO
    // ------------------------------------------------------------------
    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               push, pop, fifo_empty;
    entry_t             wr_entry, head;

    // tready comes from the registered level, so a pop at full does not reopen it this cycle
    assign s_axis_tready = !areset && (level_q != FULL_LVL);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign fifo_empty    = (level_q == '0);
    assign head          = mem_q[rd_ptr_q];
    assign fifo_level    = level_q;

    assign wr_entry.user = s_axis_tuser;
    assign wr_entry.last = s_axis_tlast;
    assign wr_entry.b    = s_axis_tdata[2*DATA_W-1:DATA_W];
    assign wr_entry.a    = s_axis_tdata[DATA_W-1:0];

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register, lane tracking, vector counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic              out_valid_q, out_valid_d;
    logic              out_finish_q, out_finish_d;
    logic              out_acc_q, out_acc_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [15:0]       vec_q, vec_d;
    logic              load, xfer;

    assign load = !out_valid_q || sendable;
    assign xfer = out_valid_q && sendable;

    assign out_A        = out_a_q;
    assign out_B        = out_b_q;
    assign out_valid    = out_valid_q;
    assign out_finish   = out_finish_q;
    assign out_acc_sign = out_acc_q;
    assign lane_idx     = lane_q;
    assign vec_count    = vec_q;

`ifdef FP_FEEDER_PAD_EN
    typedef enum logic [0:0] {StStream, StPad} state_e;
    state_e state_q, state_d;
    logic   pad_sign_q, pad_sign_d;
`endif

    // Lane of the next pair to be loaded and the completed-vector count
    always_comb begin
        lane_d = lane_q;
        vec_d  = vec_q;
        if (xfer) begin
            if (out_finish_q) begin
                lane_d = '0;
                vec_d  = vec_q + 16'd1;
            end else if (lane_q == LAST_LANE) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    // Next-state for the output register, FIFO pop and (optional) pad FSM
    always_comb begin
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_valid_d  = out_valid_q;
        out_finish_d = out_finish_q;
        out_acc_d    = out_acc_q;
        pop          = 1'b0;
`ifdef FP_FEEDER_PAD_EN
        state_d      = state_q;
        pad_sign_d   = pad_sign_q;
`endif
        if (load) begin
`ifdef FP_FEEDER_PAD_EN
            if (state_q == StPad) begin
                // Zero filler pairs keep the sign of the vector's last real pair
                out_valid_d  = 1'b1;
                out_a_d      = '0;
                out_b_d      = '0;
                out_acc_d    = pad_sign_q;
                out_finish_d = (lane_d == LAST_LANE);
                if (lane_d == LAST_LANE) begin
                    state_d = StStream;
                end
            end else
`endif
            if (!fifo_empty) begin
                pop          = 1'b1;
                out_valid_d  = 1'b1;
                out_a_d      = head.a;
                out_b_d      = head.b;
                out_acc_d    = head.user;
                out_finish_d = head.last;
`ifdef FP_FEEDER_PAD_EN
                // A short vector hands its finish over to the final pad slot
                if (head.last && (lane_d != LAST_LANE)) begin
                    out_finish_d = 1'b0;
                    state_d      = StPad;
                    pad_sign_d   = head.user;
                end
`endif
            end else begin
                out_valid_d  = 1'b0;
                out_finish_d = 1'b0;
            end
        end
    end

    // Output, lane and counter registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_finish_q <= 1'b0;
            out_acc_q    <= 1'b0;
            lane_q       <= '0;
            vec_q        <= '0;
        end else begin
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_valid_q  <= out_valid_d;
            out_finish_q <= out_finish_d;
            out_acc_q    <= out_acc_d;
            lane_q       <= lane_d;
            vec_q        <= vec_d;
        end
    end

`ifdef FP_FEEDER_PAD_EN
    // Pad FSM state and remembered sign
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StStream;
            pad_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_sign_q <= pad_sign_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_pair_stream_feeder.sv
// Self-checking bench for fp_pair_stream_feeder: directed vectors plus a random run checked
// against an expected-transfer queue built from the input vectors.
module tb_fp_pair_stream_feeder;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LANES      = 16;
    localparam int unsigned LANE_W     = 4;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic [2*DATA_W-1:0]  s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic                 s_axis_tlast = 1'b0;
    logic                 s_axis_tuser = 1'b0;
    logic                 sendable = 1'b0;
    logic [DATA_W-1:0]    out_A, out_B;
    logic                 out_valid, out_finish, out_acc_sign;
    logic [LANE_W-1:0]    lane_idx;
    logic [15:0]          vec_count;
    logic [LVL_W-1:0]     fifo_level;

    fp_pair_stream_feeder #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LANES      (LANES),
        .LANE_W     (LANE_W)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .sendable      (sendable),
        .out_A         (out_A),
        .out_B         (out_B),
        .out_valid     (out_valid),
        .out_finish    (out_finish),
        .out_acc_sign  (out_acc_sign),
        .lane_idx      (lane_idx),
        .vec_count     (vec_count),
        .fifo_level    (fifo_level)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              last;
        logic              user;
    } pair_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              fin;
        logic              acc;
        logic [LANE_W-1:0] lane;
    } xfer_t;

    pair_t in_q[$];
    xfer_t exp_q[$];

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;
    int model_vec = 0;
    int n_xfer = 0;
    int accept_cyc = -1;
    int first_valid_cyc = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = -1;
    int src_pct = 0;
    int snd_pct = 0;
    bit mon_en = 1'b1;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue one vector on the source and its expected transfers (with padding if built in)
    task automatic push_vec(input int len, input int unsigned a0, input int unsigned b0,
                            input int user_sel, input bit rnd);
        logic [DATA_W-1:0] a, b;
        logic              u, fin;
        int                n;
        u = 1'b0;
        for (int i = 0; i < len; i++) begin
            a   = rnd ? $urandom : a0 + i;
            b   = rnd ? $urandom : b0 + i;
            u   = (user_sel == 2) ? 1'($urandom_range(1)) : (user_sel == 1);
            fin = (i == len - 1);
`ifdef FP_FEEDER_PAD_EN
            fin = fin && ((i % LANES) == LANES - 1);
`endif
            in_q.push_back('{a: a, b: b, last: (i == len - 1), user: u});
            exp_q.push_back('{a: a, b: b, fin: fin, acc: u, lane: LANE_W'(i % LANES)});
        end
        n = len;
`ifdef FP_FEEDER_PAD_EN
        while ((n % LANES) != 0) begin
            exp_q.push_back('{a: '0, b: '0, fin: ((n % LANES) == LANES - 1), acc: u,
                              lane: LANE_W'(n % LANES)});
            n++;
        end
`endif
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && k < budget) begin
            @(posedge aclk);
            k++;
        end
        @(posedge aclk);
        #1;
        check(tag, 96'(exp_q.size() + in_q.size()), 96'd0);
    endtask

    always @(posedge aclk) cyc++;

    // Source: holds a pair until accepted, otherwise offers the next one at src_pct
    always begin
        bit fire;
        @(negedge aclk);
        fire = s_axis_tvalid && s_axis_tready;
        @(posedge aclk);
        #1;
        if (fire && in_q.size() != 0) begin
            void'(in_q.pop_front());
            if (accept_cyc < 0) accept_cyc = cyc;
        end
        if (areset) begin
            s_axis_tvalid = 1'b0;
        end else if (!(s_axis_tvalid && !fire)) begin
            if (in_q.size() != 0 && $urandom_range(99) < src_pct) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {in_q[0].b, in_q[0].a};
                s_axis_tlast  = in_q[0].last;
                s_axis_tuser  = in_q[0].user;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Sink
    always @(posedge aclk) begin
        #1;
        sendable = ($urandom_range(99) < snd_pct);
    end

    // Monitor: every transfer must match the next expected one
    always @(negedge aclk) begin
        xfer_t e;
        if (mon_en && !areset && out_valid && sendable) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 96'd1, 96'd0);
            end else begin
                e = exp_q.pop_front();
                check("xfer", 96'({out_A, out_B, out_finish, out_acc_sign, lane_idx}), 96'(e));
                if (e.fin) model_vec++;
                n_xfer++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    initial begin
        int x0;
        xfer_t e;

        // 1) Reset
        repeat (3) @(posedge aclk);
        #1;
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_A", 96'(out_A), 96'd0);
        check("rst_B", 96'(out_B), 96'd0);
        check("rst_finish", 96'(out_finish), 96'd0);
        check("rst_acc", 96'(out_acc_sign), 96'd0);
        check("rst_lane", 96'(lane_idx), 96'd0);
        check("rst_vec", 96'(vec_count), 96'd0);
        check("rst_level", 96'(fifo_level), 96'd0);
        check("rst_tready", 96'(s_axis_tready), 96'd0);
        areset = 1'b0;
        #1;
        check("rel_tready", 96'(s_axis_tready), 96'd1);
        check("rel_level", 96'(fifo_level), 96'd0);

        // 2) Full-lane vector at full rate
        snd_pct = 100;
        src_pct = 100;
        @(posedge aclk);
        push_vec(16, 0, 16, 0, 1'b0);
        wait_drain("t2_drain", 200);
        check("t2_latency", 96'(first_valid_cyc - accept_cyc), 96'd1);
        check("t2_consecutive", 96'(last_xfer_cyc - first_xfer_cyc), 96'd15);
        check("t2_vec", 96'(vec_count), 96'd1);
        check("t2_lane", 96'(lane_idx), 96'd0);

        // 3) Short vector with acc_sign=1
        x0 = n_xfer;
        push_vec(5, 32'h100, 32'h200, 1, 1'b0);
        wait_drain("t3_drain", 200);
`ifdef FP_FEEDER_PAD_EN
        check("t3_xfers", 96'(n_xfer - x0), 96'd16);
`else
        check("t3_xfers", 96'(n_xfer - x0), 96'd5);
`endif
        check("t3_vec", 96'(vec_count), 96'd2);
        check("t3_lane", 96'(lane_idx), 96'd0);

        // 4) Backpressure for 20 cycles
        snd_pct = 0;
        repeat (2) @(posedge aclk);
        push_vec(20, 32'h1000, 32'h2000, 2, 1'b0);
        repeat (20) @(posedge aclk);
        #2;
        check("t4_level", 96'(fifo_level), 96'(FIFO_DEPTH));
        check("t4_tready", 96'(s_axis_tready), 96'd0);
        check("t4_valid", 96'(out_valid), 96'd1);
        e = exp_q[0];
        check("t4_hold", 96'({out_A, out_B, out_finish, out_acc_sign, lane_idx}), 96'(e));
        repeat (3) @(posedge aclk);
        #2;
        check("t4_hold_later", 96'({out_A, out_B, out_finish, out_acc_sign, lane_idx}), 96'(e));
        snd_pct = 100;
        wait_drain("t4_drain", 300);
        check("t4_vec", 96'(vec_count), 96'd3);

        // 5) Reset with 6 buffered and one on the output
        snd_pct = 0;
        repeat (2) @(posedge aclk);
        push_vec(7, 32'h3000, 32'h4000, 0, 1'b0);
        repeat (14) @(posedge aclk);
        #2;
        check("t5_level", 96'(fifo_level), 96'd6);
        check("t5_valid", 96'(out_valid), 96'd1);
        @(posedge aclk);
        #1;
        src_pct = 0;
        areset = 1'b1;
        @(posedge aclk);
        #2;
        in_q.delete();
        exp_q.delete();
        check("t5_rst_valid", 96'(out_valid), 96'd0);
        check("t5_rst_level", 96'(fifo_level), 96'd0);
        check("t5_rst_vec", 96'(vec_count), 96'd0);
        areset = 1'b0;
        model_vec = 0;
        snd_pct = 100;
        src_pct = 100;
        push_vec(16, 32'h5000, 32'h6000, 0, 1'b0);
        wait_drain("t5_drain", 200);
        check("t5_vec", 96'(vec_count), 96'd1);

        // 6) Random traffic, 1000 vectors
        src_pct = 50;
        snd_pct = 50;
        for (int v = 0; v < 1000; v++) begin
            push_vec(int'($urandom_range(40, 1)), 0, 0, 2, 1'b1);
        end
        wait_drain("t6_drain", 90000);
        check("t6_vec", 96'(vec_count), 96'd1001);
        check("t6_model_vec", 96'(vec_count), 96'(16'(model_vec)));
        check("t6_level", 96'(fifo_level), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
